sd_card_read_ctrl: RTL

//  Read-side sequencer of the SD card controller, the counterpart of the write sequencer.

---
 rtl/sd_card_pkg.sv | 18 +
 rtl/sd_wait_timer.sv | 22 ++
 rtl/sd_card_read_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sd_card_pkg.sv
// sd_card_pkg: shared states, command indices and R1 status helpers for the SD card sequencers
package sd_card_pkg;
  typedef enum logic [3:0] {
    IDLE, SEND_CMD17, GET_RESP17, SEND_CMD18, GET_RESP18, GET_DATA,
    NEXT_BLOCK, SEND_CMD12, GET_RESP12, BUSY_WAIT, DONE, FAIL
  } state_t;
  localparam logic [5:0] CMD_READ_SINGLE = 6'd17;
  localparam logic [5:0] CMD_READ_MULTI  = 6'd18;
  localparam logic [5:0] CMD_STOP        = 6'd12;
  // Bit positions inside the 32-bit card status carried in frame bits [39:8]
  localparam int R1_OUT_OF_RANGE      = 31;
  localparam int R1_ADDRESS_ERROR     = 30;
  localparam int R1_CURRENT_STATE_LSB = 9;
  localparam int R1_CURRENT_STATE_MSB = 12;
  function automatic logic r1_addr_fault(input logic [31:0] status);
    return status[R1_OUT_OF_RANGE] | status[R1_ADDRESS_ERROR];
  endfunction
endpackage

// File: rtl/sd_wait_timer.sv
// sd_wait_timer: 16-bit wait counter that saturates at limit and flags expiry
//  clk, rst  : clock, asynchronous active-high reset
//  clear     : restart count from 0 (wins over enable)
//  enable    : count one per cycle while below limit
//  limit     : expiry value, compared with ==
//  count     : current count
//  expired   : count == limit
module sd_wait_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic [15:0] count,
  output logic        expired
);
  assign expired = count == limit;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (enable && !expired) count <= count + 16'd1;
endmodule

// File: rtl/sd_card_read_ctrl.sv
// sd_card_read_ctrl: CMD17/CMD18 read sequencer with CMD12 stop and R1b busy wait
//  clk, rst                : clock, asynchronous active-high reset
//  Read_Enable             : start request, held until Read_complite/Read_Fail
//  Responce_R1_R3          : last response frame, card status in [39:8]
//  SD_Addr_Block           : block address for CMD17/CMD18
//  SerialCount             : 0 = single block, N = N+1 blocks
//  CMD_ID, Arg1..Arg4      : command index and argument bytes (Arg1 = MSB)
//  Send_CMD_En/Get_CMD_En/Get_DATA_En : registered, mutually exclusive engine requests
//  Send_CMD_Complite/Get_CMD_Complite/Get_DATA_Complite/Data_CRC_Error : engine status
//  Busy_Bit                : DAT0 level, 1 = card ready
//  BlockReadCount          : index of block being received
//  Read_complite/Read_Fail : result flags
module sd_card_read_ctrl
  import sd_card_pkg::*;
#(
  parameter logic [15:0] RESP_TIMEOUT = 16'd255,
  parameter logic [15:0] DATA_TIMEOUT = 16'hFFFF,
  parameter logic [15:0] BUSY_TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Read_Enable,
  input  logic [47:0] Responce_R1_R3,
  input  logic [31:0] SD_Addr_Block,
  input  logic [31:0] SerialCount,
  output logic [5:0]  CMD_ID,
  output logic [7:0]  Arg1,
  output logic [7:0]  Arg2,
  output logic [7:0]  Arg3,
  output logic [7:0]  Arg4,
  output logic        Send_CMD_En,
  output logic        Get_CMD_En,
  output logic        Get_DATA_En,
  input  logic        Send_CMD_Complite,
  input  logic        Get_CMD_Complite,
  input  logic        Get_DATA_Complite,
  input  logic        Data_CRC_Error,
  input  logic        Busy_Bit,
  output logic [31:0] BlockReadCount,
  output logic        Read_complite,
  output logic        Read_Fail
);
  state_t state, state_n;
  logic err, err_n, expired, waiting, multi, addr_fault, unused_bits;
  logic [31:0] cnt_n, serial_q, addr_q;
  logic [15:0] limit, timer_count;
  assign multi = serial_q != 32'd0;
  assign addr_fault = r1_addr_fault(Responce_R1_R3[39:8]);
  assign unused_bits = ^{Responce_R1_R3[47:40], Responce_R1_R3[7:0], timer_count};
  assign waiting = state inside {GET_RESP17, GET_RESP18, GET_RESP12, GET_DATA, BUSY_WAIT};
  assign limit = state == GET_DATA ? DATA_TIMEOUT : state == BUSY_WAIT ? BUSY_TIMEOUT : RESP_TIMEOUT;
  assign {Arg1, Arg2, Arg3, Arg4} = CMD_ID inside {CMD_READ_SINGLE, CMD_READ_MULTI} ? addr_q : 32'h0;
  sd_wait_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_n != state),
    .enable  (waiting),
    .limit   (limit),
    .count   (timer_count),
    .expired (expired)
  );
  always_comb begin
    state_n = state;
    err_n   = err;
    cnt_n   = BlockReadCount;
    case (state)
      IDLE:       if (Read_Enable) state_n = SerialCount != 32'd0 ? SEND_CMD18 : SEND_CMD17;
      SEND_CMD17: if (Send_CMD_Complite) state_n = GET_RESP17;
      SEND_CMD18: if (Send_CMD_Complite) state_n = GET_RESP18;
      SEND_CMD12: if (Send_CMD_Complite) state_n = GET_RESP12;
      GET_RESP17, GET_RESP18, GET_RESP12:
        if (Get_CMD_Complite) state_n = addr_fault ? FAIL : state == GET_RESP12 ? BUSY_WAIT : GET_DATA;
        else if (expired) state_n = FAIL;
      GET_DATA:
        if (Get_DATA_Complite || expired) begin
          // CRC error is only meaningful alongside completion; a timeout is an error too
          err_n   = err | expired | (Get_DATA_Complite & Data_CRC_Error);
          state_n = multi ? (err_n ? SEND_CMD12 : NEXT_BLOCK) : (err_n ? FAIL : DONE);
        end
      NEXT_BLOCK:
        if (BlockReadCount == serial_q) state_n = SEND_CMD12;
        else begin
          cnt_n   = BlockReadCount + 32'd1;
          state_n = GET_DATA;
        end
      BUSY_WAIT:
        if (Busy_Bit) state_n = err ? FAIL : DONE;
        else if (expired) state_n = FAIL;
      DONE, FAIL:
        if (!Read_Enable) begin
          state_n = IDLE;
          cnt_n   = '0;
          err_n   = 1'b0;
        end
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      err            <= 1'b0;
      BlockReadCount <= '0;
      serial_q       <= '0;
      addr_q         <= '0;
      CMD_ID         <= '0;
      Send_CMD_En    <= 1'b0;
      Get_CMD_En     <= 1'b0;
      Get_DATA_En    <= 1'b0;
      Read_complite  <= 1'b0;
      Read_Fail      <= 1'b0;
    end else begin
      state          <= state_n;
      err            <= err_n;
      BlockReadCount <= cnt_n;
      if (state == IDLE && Read_Enable) begin
        serial_q <= SerialCount;
        addr_q   <= SD_Addr_Block;
      end
      // Outputs decode the next state so they are registered and change with the state
      CMD_ID        <= state_n inside {SEND_CMD17, GET_RESP17} ? CMD_READ_SINGLE :
                       state_n inside {SEND_CMD18, GET_RESP18} ? CMD_READ_MULTI :
                       state_n inside {SEND_CMD12, GET_RESP12} ? CMD_STOP : 6'd0;
      Send_CMD_En   <= state_n inside {SEND_CMD17, SEND_CMD18, SEND_CMD12};
      Get_CMD_En    <= state_n inside {GET_RESP17, GET_RESP18, GET_RESP12};
      Get_DATA_En   <= state_n == GET_DATA;
      Read_complite <= state_n == DONE;
      Read_Fail     <= state_n == FAIL;
    end
endmodule
